rocc_cmd_issuer: RTL
====================

Name: rocc_cmd_issuer

Overview:
Core-side initiator for the RoCC accelerator interface. It accepts decoded custom-opcode instructions from the pipeline, registers them onto the accelerator command channel, and tracks outstanding destination registers in a scoreboard. It matches accelerator responses against that scoreboard and returns write-back data to the integer register file through a registered stage. Instructions are stalled on RAW/WAW hazards against pending responses and on an outstanding-count limit.

Parameters:
XLEN, 64, width of integer register data (rs1/rs2/resp data)
MAX_OUTSTANDING, 4, maximum in-flight xd=1 commands awaiting response (1..15)

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  pipeline presents a custom instruction
in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
in_funct  in  7  inst funct7
in_rs1  in  5  rs1 index
in_rs2  in  5  rs2 index
in_rd  in  5  rd index
in_xd  in  1  instruction expects a response
in_xs1  in  1  rs1 value is used
in_xs2  in  1  rs2 value is used
in_opcode  in  7  inst opcode
in_rs1_data  in  XLEN  rs1 value
in_rs2_data  in  XLEN  rs2 value
rocc_cmd_valid  out  1  command to accelerator valid
rocc_cmd_ready  in  1  accelerator accepts command
rocc_cmd_bits_inst_funct/rs2/rs1/xd/xs1/xs2/rd/opcode  out  7/5/5/1/1/1/5/7  registered instruction fields
rocc_cmd_bits_rs1  out  XLEN  registered rs1 data
rocc_cmd_bits_rs2  out  XLEN  registered rs2 data
rocc_resp_valid  in  1  accelerator response valid
rocc_resp_ready  out  1  issuer accepts response
rocc_resp_bits_rd  in  5  response destination
rocc_resp_bits_data  in  XLEN  response data
rocc_busy  in  1  accelerator busy
wb_valid  out  1  register-file write request
wb_ready  in  1  register file accepts write
wb_rd  out  5  write destination
wb_data  out  XLEN  write data
busy  out  1  issuer or accelerator has work in flight
outstanding  out  4  current in-flight response count
err_unexpected_resp  out  1  sticky; response with no matching scoreboard entry

Behaviour:
- Reset (async): cmd stage empty (rocc_cmd_valid=0), wb stage empty (wb_valid=0), scoreboard all 0, outstanding=0, err_unexpected_resp=0. Data/field registers are don't-care but drive 0. Any response arriving after reset is treated as unexpected.
- Cmd stage: one-entry register.
  - Loads on accept.
  - rocc_cmd_valid held, and all cmd bits stable, until rocc_cmd_ready.
  - Accept and drain in the same cycle is allowed (full throughput).
  - 1-cycle latency from accept to rocc_cmd_valid.
- in_ready = (!rocc_cmd_valid || rocc_cmd_ready) && !hazard && !(in_xd && outstanding==MAX_OUTSTANDING).
- hazard = (in_xs1 && sb[in_rs1]) || (in_xs2 && sb[in_rs2]) || (in_xd && sb[in_rd]). It is evaluated on the current-cycle scoreboard; same-cycle clears do not unblock.
- in_ready depends combinationally on in_valid fields and rocc_cmd_ready only, never on in_valid.
- On accept with in_xd=1: outstanding+1. If in_rd!=0, set sb[in_rd]. sb[0] is never set.
- Response acceptance: rocc_resp_ready = !wb_valid || wb_ready. On response fire:
  - rd!=0 and sb[rd]=1: load wb stage (wb_rd, wb_data); wb_valid=1 next cycle.
  - rd==0 and outstanding>0: drop the response; outstanding-1.
  - Otherwise (sb[rd]=0 with rd!=0, or rd==0 with outstanding==0): drop, set err_unexpected_resp, counters unchanged.
- Write-back fire (wb_valid && wb_ready): clear sb[wb_rd]; outstanding-1. sb is cleared at write-back, not at response, so a dependent read cannot issue before the register file holds the value.
- Simultaneous events:
  - Increment and decrement in the same cycle leave outstanding unchanged.
  - Response drop (rd==0) plus wb fire in the same cycle gives outstanding-2.
  - Set and clear of different sb bits in the same cycle both take effect.
  - Set and clear of the same bit cannot coincide, because the hazard blocks it.
- outstanding never wraps: it saturates by construction via the MAX check. An underflow attempt is the err case above.
- busy = rocc_cmd_valid || wb_valid || outstanding!=0 || rocc_busy.

Test Plan:
- Single xd=1 cmd (rd=5, rs1=3, rs2=4, data 0x10/0x20): rocc_cmd_valid next cycle with those fields; outstanding=1, sb[5]=1. Resp rd=5 data 0x30 produces wb_valid with rd=5, data=0x30 one cycle later. After wb fire, outstanding=0 and busy=0.
- RAW hazard: pending rd=5, then issue with xs1=1, rs1=5: in_ready=0 until the cycle after wb fire for rd=5, then accepted. The same test with xs1=0 is accepted immediately.
- Backpressure: rocc_cmd_ready=0 for 3 cycles with a second in_valid. in_ready=0, cmd bits stable. The ready cycle both drains and loads, so back-to-back valid is maintained.
- Limit: MAX_OUTSTANDING=4, issue 4 xd cmds to rd=1..4. A 5th xd cmd (rd=6) is stalled while an xd=0 cmd still issues. A response to rd=2 plus its wb allows the 5th.
- Unexpected and rd0 cases: resp rd=9 with sb[9]=0 sets err_unexpected_resp sticky, with no wb and outstanding unchanged. An xd cmd with rd=0 followed by resp rd=0 is dropped, outstanding 1→0.
- Async reset with 2 outstanding and wb_valid=1: all outputs return to reset values immediately. A later resp rd=1 sets err_unexpected_resp.

Source files
------------

// File: rtl/rocc_cmd_issuer.sv
// RoCC command issuer: registers custom instructions onto the accelerator
// command channel and writes accelerator responses back to the register file.
module rocc_cmd_issuer #(
  parameter int XLEN = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_funct,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            in_xd,
  input  logic            in_xs1,
  input  logic            in_xs2,
  input  logic [6:0]      in_opcode,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            rocc_cmd_valid,
  input  logic            rocc_cmd_ready,
  output logic [6:0]      rocc_cmd_bits_inst_funct,
  output logic [4:0]      rocc_cmd_bits_inst_rs2,
  output logic [4:0]      rocc_cmd_bits_inst_rs1,
  output logic            rocc_cmd_bits_inst_xd,
  output logic            rocc_cmd_bits_inst_xs1,
  output logic            rocc_cmd_bits_inst_xs2,
  output logic [4:0]      rocc_cmd_bits_inst_rd,
  output logic [6:0]      rocc_cmd_bits_inst_opcode,
  output logic [XLEN-1:0] rocc_cmd_bits_rs1,
  output logic [XLEN-1:0] rocc_cmd_bits_rs2,
  input  logic            rocc_resp_valid,
  output logic            rocc_resp_ready,
  input  logic [4:0]      rocc_resp_bits_rd,
  input  logic [XLEN-1:0] rocc_resp_bits_data,
  input  logic            rocc_busy,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            busy,
  output logic [3:0]      outstanding,
  output logic            err_unexpected_resp
);

  logic [31:0] sb;
  logic [31:0] sb_nxt;
  logic [3:0]  out_nxt;
  logic        hazard;
  logic        at_limit;
  logic        in_fire;
  logic        cmd_fire;
  logic        resp_fire;
  logic        wb_fire;
  logic        resp_hit;
  logic        resp_drop;
  logic        resp_bad;
  logic        resp_rd0;

  assign hazard = (in_xs1 && sb[in_rs1])
               || (in_xs2 && sb[in_rs2])
               || (in_xd && sb[in_rd]);
  assign at_limit = in_xd
                 && (outstanding == 4'(MAX_OUTSTANDING));
  assign in_ready = (!rocc_cmd_valid || rocc_cmd_ready)
                 && !hazard && !at_limit;

  assign in_fire   = in_valid && in_ready;
  assign cmd_fire  = rocc_cmd_valid && rocc_cmd_ready;
  assign rocc_resp_ready = !wb_valid || wb_ready;
  assign resp_fire = rocc_resp_valid && rocc_resp_ready;
  assign wb_fire   = wb_valid && wb_ready;

  assign resp_rd0  = (rocc_resp_bits_rd == 5'd0);
  assign resp_hit  = resp_fire && !resp_rd0
                  && sb[rocc_resp_bits_rd];
  assign resp_drop = resp_fire && resp_rd0
                  && (outstanding != 4'd0);
  assign resp_bad  = resp_fire && !resp_hit && !resp_drop;

  assign busy = rocc_cmd_valid || wb_valid
             || (outstanding != 4'd0) || rocc_busy;

  // Next scoreboard and in-flight count; bit 0 never tracks
  always_comb begin
    sb_nxt  = sb;
    out_nxt = outstanding;
    if (wb_fire) begin
      sb_nxt[wb_rd] = 1'b0;
    end
    if (in_fire && in_xd && (in_rd != 5'd0)) begin
      sb_nxt[in_rd] = 1'b1;
    end
    sb_nxt[0] = 1'b0;
    out_nxt = outstanding
            + {3'd0, in_fire && in_xd}
            - {3'd0, wb_fire}
            - {3'd0, resp_drop};
  end

  // Scoreboard, counter and sticky error state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sb                  <= '0;
      outstanding         <= '0;
      err_unexpected_resp <= 1'b0;
    end else begin
      sb          <= sb_nxt;
      outstanding <= out_nxt;
      if (resp_bad) begin
        err_unexpected_resp <= 1'b1;
      end
    end
  end

  // One-entry command register; load on accept, empty on drain
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rocc_cmd_valid            <= 1'b0;
      rocc_cmd_bits_inst_funct  <= '0;
      rocc_cmd_bits_inst_rs2    <= '0;
      rocc_cmd_bits_inst_rs1    <= '0;
      rocc_cmd_bits_inst_xd     <= 1'b0;
      rocc_cmd_bits_inst_xs1    <= 1'b0;
      rocc_cmd_bits_inst_xs2    <= 1'b0;
      rocc_cmd_bits_inst_rd     <= '0;
      rocc_cmd_bits_inst_opcode <= '0;
      rocc_cmd_bits_rs1         <= '0;
      rocc_cmd_bits_rs2         <= '0;
    end else if (in_fire) begin
      rocc_cmd_valid            <= 1'b1;
      rocc_cmd_bits_inst_funct  <= in_funct;
      rocc_cmd_bits_inst_rs2    <= in_rs2;
      rocc_cmd_bits_inst_rs1    <= in_rs1;
      rocc_cmd_bits_inst_xd     <= in_xd;
      rocc_cmd_bits_inst_xs1    <= in_xs1;
      rocc_cmd_bits_inst_xs2    <= in_xs2;
      rocc_cmd_bits_inst_rd     <= in_rd;
      rocc_cmd_bits_inst_opcode <= in_opcode;
      rocc_cmd_bits_rs1         <= in_rs1_data;
      rocc_cmd_bits_rs2         <= in_rs2_data;
    end else if (cmd_fire) begin
      rocc_cmd_valid <= 1'b0;
    end
  end

  // Write-back register; load on matched response, empty on write
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else if (resp_hit) begin
      wb_valid <= 1'b1;
      wb_rd    <= rocc_resp_bits_rd;
      wb_data  <= rocc_resp_bits_data;
    end else if (wb_fire) begin
      wb_valid <= 1'b0;
    end
  end

endmodule
